// File: rtl/alu_reservation_station_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_reservation_station_if                                    |
// | Description : Bus bundle for the ALU reservation station. Carries the       |
// |               decoder issue port, the LSB result broadcast, and the         |
// |               ALU result port toward the ROB, plus the full flag.           |
// | Modports    : master - decoder/LSB side (drives issue and lsb_*)            |
// |               slave  - reservation station (drives rs_*)                    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

interface alu_reservation_station_if #(
  parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
);
  // issue side
  logic                    issue_valid;
  logic [3:0]              issue_op;
  logic [ROB_SIZE_BIT-1:0] issue_rob_id;
  logic [31:0]             issue_vj;
  logic [31:0]             issue_vk;
  logic                    issue_qj_busy;
  logic                    issue_qk_busy;
  logic [ROB_SIZE_BIT-1:0] issue_qj;
  logic [ROB_SIZE_BIT-1:0] issue_qk;
  // LSB result broadcast
  logic                    lsb_is_set;
  logic [ROB_SIZE_BIT-1:0] lsb_set_id;
  logic [31:0]             lsb_set_val;
  // station outputs
  logic                    rs_full;
  logic                    rs_is_set;
  logic [ROB_SIZE_BIT-1:0] rs_set_id;
  logic [31:0]             rs_set_val;

  modport master (
    output issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           lsb_is_set, lsb_set_id, lsb_set_val,
    input  rs_full, rs_is_set, rs_set_id, rs_set_val
  );

  modport slave (
    input  issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           lsb_is_set, lsb_set_id, lsb_set_val,
    output rs_full, rs_is_set, rs_set_id, rs_set_val
  );
endinterface

`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_reservation_station                                       |
// | Description : Reservation station for ALU/branch ops. Holds up to           |
// |               2^RS_SIZE_BIT entries, snoops its own ALU result and the      |
// |               LSB result to wake operands, dispatches the lowest-index      |
// |               ready entry to a single-cycle ALU and registers the result.   |
// | Ports       : clk_in, rst_in (async, active-low), rdy_in (freeze when low), |
// |               clear (flush), bus (slave modport: issue, lsb_*, rs_*).       |
// | Option      : RS_PERF_CNT_EN adds perf_issue_cnt / perf_full_cnt outputs.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module alu_reservation_station #(
  parameter int RS_SIZE_BIT  = 3,
  parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
  input  wire logic                 clk_in,
  input  wire logic                 rst_in,
  input  wire logic                 rdy_in,
  input  wire logic                 clear,
  alu_reservation_station_if.slave  bus
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]               perf_issue_cnt,
  output logic [31:0]               perf_full_cnt
`endif
);

  localparam int N = 1 << RS_SIZE_BIT;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_BGE  = 4'd13;
  localparam logic [3:0] OP_BLTU = 4'd14;
  localparam logic [3:0] OP_BGEU = 4'd15;

  // control state (reset)
  logic [N-1:0]            r_busy;
  logic                    r_full;
  logic                    r_is_set;
  logic [ROB_SIZE_BIT-1:0] r_set_id;
  logic [31:0]             r_set_val;

  // entry payload (qualified by r_busy, so no reset needed)
  logic [3:0]              r_op  [N];
  logic [ROB_SIZE_BIT-1:0] r_rob [N];
  logic [31:0]             r_vj  [N];
  logic [31:0]             r_vk  [N];
  logic [N-1:0]            r_qjb;
  logic [N-1:0]            r_qkb;
  logic [ROB_SIZE_BIT-1:0] r_qj  [N];
  logic [ROB_SIZE_BIT-1:0] r_qk  [N];

  logic [N-1:0]            w_ready;
  logic                    w_has_disp;
  logic [RS_SIZE_BIT-1:0]  w_disp_idx;
  logic [RS_SIZE_BIT-1:0]  w_free_idx;
  logic                    w_issue_acc;
  logic [N-1:0]            w_busy_next;
  logic [31:0]             w_a;
  logic [31:0]             w_b;
  logic [31:0]             w_res;
  logic [32:0]             w_iss_j;
  logic [32:0]             w_iss_k;
  logic [32:0]             w_wake_j [N];
  logic [32:0]             w_wake_k [N];

  // Returns {still_pending, value}. The ALU broadcast is checked before the
  // LSB broadcast; ROB tags are unique, so both can never match one operand.
  function automatic logic [32:0] resolve(
    input logic                    pend,
    input logic [ROB_SIZE_BIT-1:0] tag,
    input logic [31:0]             val
  );
    if (pend && r_is_set && (tag == r_set_id))
      return {1'b0, r_set_val};
    if (pend && bus.lsb_is_set && (tag == bus.lsb_set_id))
      return {1'b0, bus.lsb_set_val};
    return {pend, val};
  endfunction

  assign w_ready     = r_busy & ~r_qjb & ~r_qkb;
  // r_full is exact for the registered busy set, so !r_full guarantees a slot
  assign w_issue_acc = bus.issue_valid && !r_full;

  // lowest-index free slot and lowest-index ready slot
  always_comb begin
    w_has_disp = 1'b0;
    w_disp_idx = '0;
    w_free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = RS_SIZE_BIT'(i);
      if (w_ready[i]) begin
        w_has_disp = 1'b1;
        w_disp_idx = RS_SIZE_BIT'(i);
      end
    end
  end

  always_comb begin
    w_busy_next = r_busy;
    if (w_has_disp)  w_busy_next[w_disp_idx] = 1'b0;
    if (w_issue_acc) w_busy_next[w_free_idx] = 1'b1;
  end

  always_comb begin
    w_iss_j = resolve(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
    w_iss_k = resolve(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
    for (int i = 0; i < N; i++) begin
      w_wake_j[i] = resolve(r_qjb[i], r_qj[i], r_vj[i]);
      w_wake_k[i] = resolve(r_qkb[i], r_qk[i], r_vk[i]);
    end
  end

  // single-cycle ALU on the selected entry
  always_comb begin
    w_a   = r_vj[w_disp_idx];
    w_b   = r_vk[w_disp_idx];
    w_res = '0;
    case (r_op[w_disp_idx])
      OP_ADD:  w_res = w_a + w_b;
      OP_SUB:  w_res = w_a - w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_SLL:  w_res = w_a << w_b[4:0];
      OP_SRL:  w_res = w_a >> w_b[4:0];
      OP_SRA:  w_res = $signed(w_a) >>> w_b[4:0];
      OP_SLT:  w_res = {31'b0, $signed(w_a) < $signed(w_b)};
      OP_SLTU: w_res = {31'b0, w_a < w_b};
      OP_BEQ:  w_res = {31'b0, w_a == w_b};
      OP_BNE:  w_res = {31'b0, w_a != w_b};
      OP_BLT:  w_res = {31'b0, $signed(w_a) < $signed(w_b)};
      OP_BGE:  w_res = {31'b0, $signed(w_a) >= $signed(w_b)};
      OP_BLTU: w_res = {31'b0, w_a < w_b};
      OP_BGEU: w_res = {31'b0, w_a >= w_b};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy    <= '0;
      r_full    <= 1'b0;
      r_is_set  <= 1'b0;
      r_set_id  <= '0;
      r_set_val <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy   <= '0;
        r_full   <= 1'b0;
        r_is_set <= 1'b0;
      end else begin
        r_busy   <= w_busy_next;
        r_full   <= &w_busy_next;
        r_is_set <= w_has_disp;
        if (w_has_disp) begin
          r_set_id  <= r_rob[w_disp_idx];
          r_set_val <= w_res;
        end
      end
    end
  end

  // The issue slot is never busy, so it cannot collide with wakeup updates.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear) begin
      for (int i = 0; i < N; i++) begin
        if (w_issue_acc && (w_free_idx == RS_SIZE_BIT'(i))) begin
          r_op[i]              <= bus.issue_op;
          r_rob[i]             <= bus.issue_rob_id;
          r_qj[i]              <= bus.issue_qj;
          r_qk[i]              <= bus.issue_qk;
          {r_qjb[i], r_vj[i]}  <= w_iss_j;
          {r_qkb[i], r_vk[i]}  <= w_iss_k;
        end else if (r_busy[i]) begin
          {r_qjb[i], r_vj[i]}  <= w_wake_j[i];
          {r_qkb[i], r_vk[i]}  <= w_wake_k[i];
        end
      end
    end
  end

  assign bus.rs_full    = r_full;
  assign bus.rs_is_set  = r_is_set;
  assign bus.rs_set_id  = r_set_id;
  assign bus.rs_set_val = r_set_val;

`ifdef RS_PERF_CNT_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_full;

  // counters survive a flush; only reset clears them
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_perf_issue <= '0;
      r_perf_full  <= '0;
    end else if (rdy_in) begin
      if (w_issue_acc && !clear) r_perf_issue <= r_perf_issue + 32'd1;
      if (r_full && bus.issue_valid) r_perf_full <= r_perf_full + 32'd1;
    end
  end

  assign perf_issue_cnt = r_perf_issue;
  assign perf_full_cnt  = r_perf_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_alu_reservation_station                                    |
// | Description : Self-checking bench for alu_reservation_station: directed     |
// |               scenarios with literal expectations, then random traffic      |
// |               compared every negedge against a slot-array reference model.  |
// | Option      : RS_PERF_CNT_EN also checks the performance counters.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_alu_reservation_station;
  localparam int RW = 4;
  localparam int N  = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;
  logic clear  = 1'b0;
  bit   done   = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station_if #(.ROB_SIZE_BIT(RW)) bus ();

`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_full_cnt;
`endif

  alu_reservation_station #(.RS_SIZE_BIT(3), .ROB_SIZE_BIT(RW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
`ifdef RS_PERF_CNT_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_full_cnt  (perf_full_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic          v;
    logic [3:0]    op;
    logic [RW-1:0] rob;
    logic [31:0]   a, b;
    logic          pa, pb;
    logic [RW-1:0] ta, tb;
  } ent_t;

  ent_t          m [N];
  logic          m_is_set;
  logic [RW-1:0] m_id;
  logic [31:0]   m_val;
  logic          m_full;
  int unsigned   m_icnt, m_fcnt;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    logic [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return {31'b0, sa < sb};
      4'd9:  return {31'b0, a < b};
      4'd10: return {31'b0, a == b};
      4'd11: return {31'b0, a != b};
      4'd12: return {31'b0, sa < sb};
      4'd13: return {31'b0, sa >= sb};
      4'd14: return {31'b0, a < b};
      default: return {31'b0, a >= b};
    endcase
  endfunction

  function automatic logic [32:0] snoop(input logic p, input logic [RW-1:0] t, input logic [31:0] v);
    if (p && m_is_set && t == m_id) return {1'b0, m_val};
    if (p && bus.lsb_is_set && t == bus.lsb_set_id) return {1'b0, bus.lsb_set_val};
    return {p, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].v = 1'b0;
    m_is_set = 1'b0; m_id = '0; m_val = '0; m_full = 1'b0;
    m_icnt = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    int d, f, cnt;
    logic [31:0] res;
    logic [RW-1:0] rid;
    logic [32:0] w;
    if (m_full && bus.issue_valid) m_fcnt++;
    if (clear) begin
      for (int i = 0; i < N; i++) m[i].v = 1'b0;
      m_is_set = 1'b0; m_full = 1'b0;
      return;
    end
    d = -1; f = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i].v && !m[i].pa && !m[i].pb) d = i;
      if (!m[i].v) f = i;
    end
    res = '0; rid = '0;
    if (d >= 0) begin
      res = alu_ref(m[d].op, m[d].a, m[d].b);
      rid = m[d].rob;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].v) begin
        w = snoop(m[i].pa, m[i].ta, m[i].a); m[i].pa = w[32]; m[i].a = w[31:0];
        w = snoop(m[i].pb, m[i].tb, m[i].b); m[i].pb = w[32]; m[i].b = w[31:0];
      end
    end
    if (bus.issue_valid && !m_full && f >= 0) begin
      m[f].v = 1'b1; m[f].op = bus.issue_op; m[f].rob = bus.issue_rob_id;
      m[f].ta = bus.issue_qj; m[f].tb = bus.issue_qk;
      w = snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj); m[f].pa = w[32]; m[f].a = w[31:0];
      w = snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk); m[f].pb = w[32]; m[f].b = w[31:0];
      m_icnt++;
    end
    if (d >= 0) begin
      m[d].v = 1'b0; m_is_set = 1'b1; m_id = rid; m_val = res;
    end else begin
      m_is_set = 1'b0;
    end
    cnt = 0;
    for (int i = 0; i < N; i++) if (m[i].v) cnt++;
    m_full = (cnt == N);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (!done) begin
        chk("model.rs_is_set",  {31'b0, bus.rs_is_set}, {31'b0, m_is_set});
        chk("model.rs_set_id",  {28'b0, bus.rs_set_id}, {28'b0, m_id});
        chk("model.rs_set_val", bus.rs_set_val, m_val);
        chk("model.rs_full",    {31'b0, bus.rs_full},   {31'b0, m_full});
`ifdef RS_PERF_CNT_EN
        chk("model.perf_issue", perf_issue_cnt, m_icnt);
        chk("model.perf_full",  perf_full_cnt,  m_fcnt);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk_in);
    if (rst_in && rdy_in) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_op = '0; bus.issue_rob_id = '0;
    bus.issue_vj = '0; bus.issue_vk = '0;
    bus.issue_qj_busy = 0; bus.issue_qk_busy = 0; bus.issue_qj = '0; bus.issue_qk = '0;
    bus.lsb_is_set = 0; bus.lsb_set_id = '0; bus.lsb_set_val = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [RW-1:0] rob, input logic [31:0] vj,
                       input logic [31:0] vk, input logic qjb, input logic [RW-1:0] qj);
    bus.issue_valid = 1; bus.issue_op = op; bus.issue_rob_id = rob;
    bus.issue_vj = vj; bus.issue_vk = vk;
    bus.issue_qj_busy = qjb; bus.issue_qj = qj; bus.issue_qk_busy = 0; bus.issue_qk = '0;
    cycle();
    bus.issue_valid = 0; bus.issue_qj_busy = 0;
  endtask

  task automatic lsb(input logic [RW-1:0] id, input logic [31:0] val);
    bus.lsb_is_set = 1; bus.lsb_set_id = id; bus.lsb_set_val = val;
    cycle();
    bus.lsb_is_set = 0;
  endtask

  task automatic chk_res(input string name, input logic [RW-1:0] id, input logic [31:0] val);
    chk({name, ".is_set"}, {31'b0, bus.rs_is_set}, 32'd1);
    chk({name, ".id"},     {28'b0, bus.rs_set_id}, {28'b0, id});
    chk({name, ".val"},    bus.rs_set_val, val);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [RW-1:0] t;
    idle_inputs();
    model_reset();
    rst_in = 0; rdy_in = 1;
    #2;
    chk("reset.is_set", {31'b0, bus.rs_is_set}, 32'd0);
    chk("reset.id",     {28'b0, bus.rs_set_id}, 32'd0);
    chk("reset.val",    bus.rs_set_val, 32'd0);
    chk("reset.full",   {31'b0, bus.rs_full}, 32'd0);
    cycle(); cycle();
    rst_in = 1;
    cycle();

    // ADD 5+7, both ready: result two cycles after issue, then drops
    issue(4'd0, 4'd3, 32'd5, 32'd7, 0, '0);
    cycle();
    chk_res("add", 4'd3, 32'd12);
    cycle();
    chk("add.drop", {31'b0, bus.rs_is_set}, 32'd0);

    // SUB waiting on tag 6, woken by LSB value 10
    issue(4'd1, 4'd2, 32'd0, 32'd1, 1, 4'd6);
    cycle();
    chk("sub.wait", {31'b0, bus.rs_is_set}, 32'd0);
    lsb(4'd6, 32'd10);
    cycle();
    chk_res("sub", 4'd2, 32'd9);

    // signed vs unsigned branch compare
    issue(4'd12, 4'd5, 32'hFFFF_FFFF, 32'd1, 0, '0);
    issue(4'd14, 4'd6, 32'hFFFF_FFFF, 32'd1, 0, '0);
    chk_res("blt", 4'd5, 32'd1);
    cycle();
    chk_res("bltu", 4'd6, 32'd0);

    // operand satisfied by a broadcast in the issue cycle itself
    bus.lsb_is_set = 1; bus.lsb_set_id = 4'd4; bus.lsb_set_val = 32'd8;
    issue(4'd0, 4'd7, 32'd0, 32'd2, 1, 4'd4);
    bus.lsb_is_set = 0;
    cycle();
    chk_res("fwd", 4'd7, 32'd10);

    // fill all 8 slots on tag 9, then drain in index order
    for (int i = 0; i < N; i++) issue(4'd0, RW'(i), 32'd0, 32'(i), 1, 4'd9);
    chk("fill.full", {31'b0, bus.rs_full}, 32'd1);
    lsb(4'd9, 32'd100);
    for (int i = 0; i < N; i++) begin
      cycle();
      chk_res("drain", RW'(i), 32'd100 + 32'(i));
      if (i == 0) chk("drain.full", {31'b0, bus.rs_full}, 32'd0);
    end

    // flush with 3 waiting entries and a simultaneous ready issue
    for (int i = 0; i < 3; i++) issue(4'd0, RW'(i + 1), 32'd1, 32'd1, 1, 4'd12);
    clear = 1;
    issue(4'd0, 4'd4, 32'd1, 32'd1, 0, '0);
    clear = 0;
    chk("clear.is_set", {31'b0, bus.rs_is_set}, 32'd0);
    chk("clear.full",   {31'b0, bus.rs_full}, 32'd0);
    lsb(4'd12, 32'd55);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("clear.nodisp", {31'b0, bus.rs_is_set}, 32'd0);
    end

    // asynchronous reset while a result is on the bus
    issue(4'd4, 4'd11, 32'hF0F0_0000, 32'h0F0F_0001, 0, '0);
    issue(4'd0, 4'd12, 32'd1, 32'd2, 0, '0);
    chk_res("xor", 4'd11, 32'hFFFF_0001);
    rst_in = 0; model_reset();
    #1;
    chk("arst.is_set", {31'b0, bus.rs_is_set}, 32'd0);
    chk("arst.id",     {28'b0, bus.rs_set_id}, 32'd0);
    chk("arst.val",    bus.rs_set_val, 32'd0);
    cycle();
    rst_in = 1;
    cycle();
    chk("arst.nodisp", {31'b0, bus.rs_is_set}, 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(7) != 0);
      clear  = ($urandom_range(80) == 0);
      bus.issue_valid   = ($urandom_range(2) != 0);
      bus.issue_op      = 4'($urandom_range(15));
      bus.issue_rob_id  = RW'($urandom_range(15));
      bus.issue_vj      = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      case ($urandom_range(3))
        0:       bus.issue_vk = bus.issue_vj;
        1:       bus.issue_vk = 32'($urandom_range(40));
        default: bus.issue_vk = $urandom;
      endcase
      bus.issue_qj_busy = ($urandom_range(2) == 0);
      bus.issue_qk_busy = ($urandom_range(2) == 0);
      bus.issue_qj      = RW'($urandom_range(15));
      bus.issue_qk      = RW'($urandom_range(15));
      bus.lsb_is_set    = ($urandom_range(1) == 0);
      t = RW'($urandom_range(15));
      // keep the two broadcast tags distinct, as unique ROB tags guarantee
      if (m_is_set && t == m_id) t = t + 1'b1;
      bus.lsb_set_id    = t;
      bus.lsb_set_val   = $urandom;
      cycle();
    end

    rdy_in = 1; clear = 0;
    idle_inputs();
    cycle();
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station for ALU and branch instructions, between the decoder (issue side) and the reorder buffer's RS result port (rs_is_set / rs_set_id / rs_set_val).
- Holds up to 2^RS_SIZE_BIT waiting instructions and snoops the two result broadcasts (its own ALU output and the LSB output) to wake operands.
- Dispatches the lowest-index ready entry to a one-cycle ALU and drives its result to the ROB.

Parameters:
- RS_SIZE_BIT, 3, log2 of entry count (8 entries).
- ROB_SIZE_BIT, `ROB_WIDTH_BIT, width of ROB tags.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; state frozen when low.
- clear  input  1  mispredict flush; acts when clear && rdy_in.
- issue_valid  input  1  decoder presents an instruction this cycle.
- issue_op  input  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 BEQ,11 BNE,12 BLT,13 BGE,14 BLTU,15 BGEU.
- issue_rob_id  input  ROB_SIZE_BIT  destination ROB tag.
- issue_vj, issue_vk  input  32  operand values, valid when the matching q_busy is 0.
- issue_qj_busy, issue_qk_busy  input  1  operand still pending.
- issue_qj, issue_qk  input  ROB_SIZE_BIT  producer tags.
- lsb_is_set  input  1  LSB result broadcast valid.
- lsb_set_id  input  ROB_SIZE_BIT  LSB result tag.
- lsb_set_val  input  32  LSB result value.
- rs_full  output  1  no free entry.
- rs_is_set  output  1  ALU result valid (registered).
- rs_set_id  output  ROB_SIZE_BIT  result ROB tag.
- rs_set_val  output  32  result; for branches bit0 = taken, bits 31:1 = 0.

Behaviour:
- Reset (rst_in low, asynchronous): all entries invalid; rs_is_set=0, rs_set_id=0, rs_set_val=0, rs_full=0.
- clear && rdy_in at a clock edge:
  - All entries invalid; rs_is_set=0 next cycle.
  - A simultaneous issue is dropped.
- rdy_in low: no state change; outputs hold.
- Entry fields: busy, op, rob_id, vj, vk, qj_busy, qk_busy, qj, qk.
- Issue, when issue_valid && !rs_full:
  - Write the lowest-index free entry.
  - If issue_qj_busy and a broadcast this cycle matches issue_qj, store the broadcast value with qj_busy=0. Same for k.
  - issue_valid while rs_full: ignored. The decoder must not do this.
- Wakeup, every cycle:
  - Sources: rs_is_set with rs_set_id/rs_set_val, and lsb_is_set with lsb_set_id/lsb_set_val.
  - For each busy entry, a pending qj or qk matching either tag captures that value and clears its busy bit.
  - Both sources may match different operands in the same cycle.
- Dispatch:
  - An entry is ready when busy && !qj_busy && !qk_busy, evaluated on registered state.
  - Select the lowest-index ready entry, compute, and register the result: rs_is_set=1, rs_set_id=rob_id, rs_set_val=result on the next edge.
  - Free the entry on that same edge.
  - At most one dispatch per cycle. No ready entry: rs_is_set=0 next cycle.
- Latency:
  - Issue with both operands ready: dispatch earliest in the cycle after issue; result visible the cycle after that.
  - Wakeup-to-dispatch: 1 cycle.
- Arithmetic:
  - 32-bit wraparound.
  - Shift amount = vk[4:0].
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
  - SLT/SLTU return 0 or 1.
- Same-cycle issue and dispatch are allowed. The freed slot becomes reusable on the next cycle.
- rs_full = (number of busy entries == 2^RS_SIZE_BIT), registered. It deasserts the cycle after a dispatch frees a slot.

Optional Feature:
- Macro: RS_PERF_CNT_EN.
- Defined: adds outputs perf_issue_cnt[31:0] (increments per accepted issue) and perf_full_cnt[31:0] (increments per cycle with rs_full && issue_valid && rdy_in).
  - Both are zeroed by reset only, not by clear, and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Issue ADD vj=5, vk=7, both ready, rob_id=3 → two cycles later rs_is_set=1, rs_set_id=3, rs_set_val=12; next cycle rs_is_set=0.
- Issue SUB qj_busy=1 qj=6, vk=1, rob_id=2; later lsb_is_set=1, lsb_set_id=6, lsb_set_val=10 → the following cycle's result: rs_set_id=2, rs_set_val=9.
- Issue BLT with vj=0xFFFFFFFF, vk=1 → rs_set_val=1. BLTU with the same operands → rs_set_val=0.
- Issue with qj=4 in the same cycle lsb_is_set=1, lsb_set_id=4, lsb_set_val=8, op ADD vk=2 → result 10; no deadlock.
- Issue 8 entries all waiting on tag 9 → rs_full=1. Broadcast tag 9 → entries dispatch in index order 0..7, one per cycle; rs_full=0 after the first dispatch.
- 3 busy entries, then assert clear with rdy_in=1 → rs_is_set=0 and no dispatch afterwards. Pulse rst_in low mid-dispatch → outputs 0 immediately.
